// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 host transmitter and
//             the scan-code receiver that sits beside it.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  // Bit index of the stop bit: 0..7 data, 8 parity, 9 stop
  localparam logic [3:0] STOP_BIT_IDX = 4'd9;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx_if
//  Purpose  : Command handshake and status bundle of the PS/2 host
//             transmitter. master = command source, slave = transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, busy, done, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Purpose  : Two-flop synchronisers for the raw PS/2 clock and data pins and
//             a falling-edge detector on the synchronised clock. Shared with
//             the scan-code receiver.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic c_in,
  input  logic d_in,
  output logic c_sync,
  output logic d_sync,
  output logic c_fall
);

  logic c_meta_q, c_sync_q, c_prev_q;
  logic d_meta_q, d_sync_q;

  // Synchronise both pins; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      c_prev_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= c_in;
      c_sync_q <= c_meta_q;
      c_prev_q <= c_sync_q;
      d_meta_q <= d_in;
      d_sync_q <= d_meta_q;
    end
  end

  assign c_sync = c_sync_q;
  assign d_sync = d_sync_q;
  assign c_fall = c_prev_q & ~c_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 command sequencer. Inhibits the clock,
//             issues request-to-send, shifts out one byte with odd parity on
//             device clock falls, then checks the device ACK bit. Drives the
//             pins open-drain (pull-low only) and blocks the receiver while
//             busy.
//  Config   : PS2_TIMEOUT_EN - abort when the device stops clocking.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_c_in,
  input  logic         ps2_d_in,
  output logic         ps2_c_oe,
  output logic         ps2_d_oe,
  output logic         rx_block,
  ps2_host_tx_if.slave cmd
);

  localparam int CYC_PER_US  = CLK_HZ / 1_000_000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
`ifdef PS2_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [8:0]       shift_q, shift_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             c_sync, d_sync, c_fall;
  logic             busy;

  ps2_line_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .c_in   (ps2_c_in),
    .d_in   (ps2_d_in),
    .c_sync (c_sync),
    .d_sync (d_sync),
    .c_fall (c_fall)
  );

  // Next-state logic: transfer sequencing, bit shifting and status pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    c_oe_d     = c_oe_q;
    d_oe_d     = d_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          shift_d    = {odd_parity(cmd.cmd_data), cmd.cmd_data};
          cnt_d      = '0;
          c_oe_d     = 1'b1;
          d_oe_d     = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          d_oe_d  = 1'b1;
          state_d = ST_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RTS: begin
        // Start bit stays driven low; releasing the clock hands it to the device
        c_oe_d    = 1'b0;
        bit_idx_d = '0;
        cnt_d     = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (c_fall) begin
          cnt_d = '0;
          if (bit_idx_q == STOP_BIT_IDX) begin
            d_oe_d  = 1'b0;
            state_d = ST_ACK;
          end else begin
            d_oe_d    = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (c_fall) begin
          cnt_d = '0;
          if (!d_sync) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (c_fall) begin
          cnt_d = '0;
        end
        if (c_sync && d_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

`ifdef PS2_TIMEOUT_EN
    // Device-clock watchdog; a normal completion in the same cycle wins
    if ((state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        !c_fall && state_d == state_q) begin
      if (cnt_q == TIMEOUT_LAST) begin
        c_oe_d     = 1'b0;
        d_oe_d     = 1'b0;
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      c_oe_q     <= 1'b0;
      d_oe_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      c_oe_q     <= c_oe_d;
      d_oe_q     <= d_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign rx_block      = busy;
  assign ps2_c_oe      = c_oe_q;
  assign ps2_d_oe      = d_oe_q;
  assign cmd.cmd_ready = ~busy;
  assign cmd.busy      = busy;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.err_code  = err_code_q;

endmodule
`default_nettype wire
